instruction_decoder: RTL and testbench

Multi-cycle control sequencer for the 16-bit CPU.
- Takes a two-word instruction (i_ir1 = opcode word, i_ir2 = operand word).
- Steps through one-hot micro-states, driving ALU opcode, register selectors and memory strobes for the datapath.
- Sits between the instruction registers and the datapath/memory interface.
- Unsupported instruction classes lock it into a sticky error state.

---
 rtl/instruction_decoder_pkg.sv | 56 +++++
 rtl/instruction_decoder.sv | 127 ++++++++++++
 tb/tb_instruction_decoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/instruction_decoder_pkg.sv
// Shared encodings for the instruction decoder: one-hot states, modes,
// register codes, ALU ops and instruction-word field positions.
package instruction_decoder_pkg;

    localparam int unsigned STATE_W = 16;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned MODE_W  = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REG_W   = 4;

    // One-hot bit index of each micro-state within o_state
    localparam int unsigned BIT_DECODE = 0;
    localparam int unsigned BIT_EXEC   = 1;
    localparam int unsigned BIT_ADDR   = 2;
    localparam int unsigned BIT_MEM    = 3;
    localparam int unsigned BIT_WB     = 4;
    localparam int unsigned BIT_DATA   = 5;
    localparam int unsigned BIT_ERR    = 15;

    typedef enum logic [STATE_W-1:0] {
        ST_DECODE = STATE_W'(1) << BIT_DECODE,
        ST_EXEC   = STATE_W'(1) << BIT_EXEC,
        ST_ADDR   = STATE_W'(1) << BIT_ADDR,
        ST_MEM    = STATE_W'(1) << BIT_MEM,
        ST_WB     = STATE_W'(1) << BIT_WB,
        ST_DATA   = STATE_W'(1) << BIT_DATA,
        ST_ERR    = STATE_W'(1) << BIT_ERR
    } state_e;

    localparam logic [MODE_W-1:0] MODE_ALU_RR = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_ALU_RI = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_LOAD   = MODE_W'(2);
    localparam logic [MODE_W-1:0] MODE_STORE  = MODE_W'(3);

    localparam logic [REG_W-1:0] REG_ZERO = REG_W'(4'h0);
    localparam logic [REG_W-1:0] REG_IMM  = REG_W'(4'hC);
    localparam logic [REG_W-1:0] REG_MDR  = REG_W'(4'hD);
    localparam logic [REG_W-1:0] REG_MAR  = REG_W'(4'hE);

    localparam logic [OP_W-1:0] ALU_NOP    = OP_W'(6'h00);
    localparam logic [OP_W-1:0] ALU_ADD    = OP_W'(6'h01);
    localparam logic [OP_W-1:0] ALU_PASS_A = OP_W'(6'h02);

    // Field slices: word 1 = mode/alu_op/dest, word 2 = src1/src2/imm8
    localparam int unsigned IR1_MODE_MSB = 15;
    localparam int unsigned IR1_MODE_LSB = 12;
    localparam int unsigned IR1_OP_MSB   = 11;
    localparam int unsigned IR1_OP_LSB   = 6;
    localparam int unsigned IR1_DEST_MSB = 5;
    localparam int unsigned IR1_DEST_LSB = 2;
    localparam int unsigned IR2_SRC1_MSB = 15;
    localparam int unsigned IR2_SRC1_LSB = 12;
    localparam int unsigned IR2_SRC2_MSB = 11;
    localparam int unsigned IR2_SRC2_LSB = 8;

endpackage

// File: rtl/instruction_decoder.sv
// Multi-cycle control sequencer: decodes a two-word instruction and walks
// one-hot micro-states, Moore-driving ALU selects and memory strobes.
module instruction_decoder
    import instruction_decoder_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [WORD_W-1:0]   i_ir1,
    input  logic [WORD_W-1:0]   i_ir2,
    output logic [STATE_W-1:0]  o_state,
    output logic                o_err,
    output logic [OP_W-1:0]     o_alu_op,
    output logic [REG_W-1:0]    o_s1,
    output logic [REG_W-1:0]    o_s2,
    output logic [REG_W-1:0]    o_dest,
    output logic                o_mem_wr,
    output logic                o_mem_rd
);

    state_e             state_q;
    state_e             state_d;
    logic [MODE_W-1:0]  mode_q;
    logic [OP_W-1:0]    alu_op_q;
    logic [REG_W-1:0]   dest_q;
    logic [REG_W-1:0]   src1_q;
    logic [REG_W-1:0]   src2_q;
    logic [MODE_W-1:0]  mode_in;

    // Reserved bits and imm8 belong to the datapath, not the sequencer
    logic               unused_ir_bits;
    assign unused_ir_bits = ^{i_ir1[1:0], i_ir2[7:0]};

    assign mode_in = i_ir1[IR1_MODE_MSB:IR1_MODE_LSB];

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_DECODE;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction copy captured in DECODE so later states ignore IR changes
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mode_q   <= '0;
            alu_op_q <= '0;
            dest_q   <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
        end else if (state_q == ST_DECODE) begin
            mode_q   <= mode_in;
            alu_op_q <= i_ir1[IR1_OP_MSB:IR1_OP_LSB];
            dest_q   <= i_ir1[IR1_DEST_MSB:IR1_DEST_LSB];
            src1_q   <= i_ir2[IR2_SRC1_MSB:IR2_SRC1_LSB];
            src2_q   <= i_ir2[IR2_SRC2_MSB:IR2_SRC2_LSB];
        end
    end

    // Next-state logic; any non-one-hot encoding falls back to DECODE
    always_comb begin
        state_d = ST_DECODE;
        case (state_q)
            ST_DECODE: begin
                if (mode_in == MODE_ALU_RR || mode_in == MODE_ALU_RI) begin
                    state_d = ST_EXEC;
                end else if (mode_in == MODE_LOAD || mode_in == MODE_STORE) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_ERR;
                end
            end
            ST_EXEC: state_d = ST_DECODE;
            ST_ADDR: state_d = (mode_q == MODE_STORE) ? ST_DATA : ST_MEM;
            ST_MEM:  state_d = (mode_q == MODE_LOAD) ? ST_WB : ST_DECODE;
            ST_WB:   state_d = ST_DECODE;
            ST_DATA: state_d = ST_MEM;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_DECODE;
        endcase
    end

    // Moore output decode from the state and latched instruction
    always_comb begin
        o_err    = 1'b0;
        o_alu_op = ALU_NOP;
        o_s1     = REG_ZERO;
        o_s2     = REG_ZERO;
        o_dest   = REG_ZERO;
        o_mem_wr = 1'b0;
        o_mem_rd = 1'b0;
        case (state_q)
            ST_EXEC: begin
                o_alu_op = alu_op_q;
                o_s1     = src1_q;
                o_s2     = (mode_q == MODE_ALU_RI) ? REG_IMM : src2_q;
                o_dest   = dest_q;
            end
            ST_ADDR: begin
                o_alu_op = ALU_ADD;
                o_s1     = src1_q;
                o_s2     = REG_IMM;
                o_dest   = REG_MAR;
            end
            ST_MEM: begin
                o_mem_rd = (mode_q == MODE_LOAD);
                o_mem_wr = (mode_q == MODE_STORE);
            end
            ST_WB: begin
                o_alu_op = ALU_PASS_A;
                o_s1     = REG_MDR;
                o_dest   = dest_q;
            end
            ST_DATA: begin
                o_alu_op = ALU_PASS_A;
                o_s1     = src2_q;
                o_dest   = REG_MDR;
            end
            ST_ERR:  o_err = 1'b1;
            default: ;
        endcase
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed-vector bench for instruction_decoder with hand-computed expectations.
module tb_instruction_decoder;

    logic        clk;
    logic        rst_n;
    logic [15:0] ir1;
    logic [15:0] ir2;
    logic [15:0] state;
    logic        err;
    logic [5:0]  alu_op;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  dest;
    logic        mem_wr;
    logic        mem_rd;

    int unsigned n_vec;
    int unsigned n_bad;

    instruction_decoder u_dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_ir1    (ir1),
        .i_ir2    (ir2),
        .o_state  (state),
        .o_err    (err),
        .o_alu_op (alu_op),
        .o_s1     (s1),
        .o_s2     (s2),
        .o_dest   (dest),
        .o_mem_wr (mem_wr),
        .o_mem_rd (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outs(input string tag, input logic [15:0] e_state, input logic e_err,
                               input logic [5:0] e_op, input logic [3:0] e_s1, input logic [3:0] e_s2,
                               input logic [3:0] e_dest, input logic e_wr, input logic e_rd);
        chk({tag, ".state"},   32'(state),  32'(e_state));
        chk({tag, ".err"},     32'(err),    32'(e_err));
        chk({tag, ".alu_op"},  32'(alu_op), 32'(e_op));
        chk({tag, ".s1"},      32'(s1),     32'(e_s1));
        chk({tag, ".s2"},      32'(s2),     32'(e_s2));
        chk({tag, ".dest"},    32'(dest),   32'(e_dest));
        chk({tag, ".mem_wr"},  32'(mem_wr), 32'(e_wr));
        chk({tag, ".mem_rd"},  32'(mem_rd), 32'(e_rd));
        chk({tag, ".onehot"},  32'($countones(state)), 32'd1);
        chk({tag, ".rdwr"},    32'(mem_rd & mem_wr), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        ir1   = 16'h0000;
        ir2   = 16'h3000;

        // Reset state
        tick();
        tick();
        expect_outs("reset", 16'h0001, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 0);

        // Mode 0 reg-reg loop: DECODE/EXEC alternating
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_outs("rr_exec", 16'h0002, 0, 6'h00, 4'h3, 4'h0, 4'h0, 0, 0);
            tick();
            expect_outs("rr_dec", 16'h0001, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 0);
        end

        // Load sequence
        rst_n = 1'b0;
        tick();
        expect_outs("ld_rst", 16'h0001, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 0);
        ir1   = 16'h2000;
        rst_n = 1'b1;
        tick();
        expect_outs("ld_addr", 16'h0004, 0, 6'h01, 4'h3, 4'hC, 4'hE, 0, 0);
        tick();
        expect_outs("ld_mem", 16'h0008, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 1);
        tick();
        expect_outs("ld_wb", 16'h0010, 0, 6'h02, 4'hD, 4'h0, 4'h0, 0, 0);
        tick();
        expect_outs("ld_dec", 16'h0001, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 0);

        // Store sequence
        ir1 = 16'h3048;
        ir2 = 16'h5700;
        tick();
        expect_outs("st_addr", 16'h0004, 0, 6'h01, 4'h5, 4'hC, 4'hE, 0, 0);
        tick();
        expect_outs("st_data", 16'h0020, 0, 6'h02, 4'h7, 4'h0, 4'hD, 0, 0);
        tick();
        expect_outs("st_mem", 16'h0008, 0, 6'h00, 4'h0, 4'h0, 4'h0, 1, 0);
        tick();
        expect_outs("st_dec", 16'h0001, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 0);

        // Mode 1 reg-imm: s2 forced to IMM
        ir1 = 16'h1108;
        tick();
        expect_outs("ri_exec", 16'h0002, 0, 6'h04, 4'h5, 4'hC, 4'h2, 0, 0);
        tick();
        expect_outs("ri_dec", 16'h0001, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 0);

        // Illegal mode locks into ERR until reset
        ir1 = 16'h7000;
        tick();
        expect_outs("err_in", 16'h8000, 1, 6'h00, 4'h0, 4'h0, 4'h0, 0, 0);
        ir1 = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("err_hold.state", 32'(state), 32'h8000);
            chk("err_hold.err", 32'(err), 32'd1);
        end
        rst_n = 1'b0;
        tick();
        expect_outs("err_rst", 16'h0001, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 0);
        rst_n = 1'b1;

        // IR change during MEM of a load is ignored
        ir1 = 16'h2000;
        ir2 = 16'h3000;
        tick();
        expect_outs("chg_addr", 16'h0004, 0, 6'h01, 4'h3, 4'hC, 4'hE, 0, 0);
        tick();
        expect_outs("chg_mem", 16'h0008, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 1);
        ir1 = 16'h0000;
        tick();
        expect_outs("chg_wb", 16'h0010, 0, 6'h02, 4'hD, 4'h0, 4'h0, 0, 0);
        tick();
        expect_outs("chg_dec", 16'h0001, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 0);

        // Reset asserted mid-ADDR
        ir1 = 16'h2000;
        tick();
        expect_outs("mid_addr", 16'h0004, 0, 6'h01, 4'h3, 4'hC, 4'hE, 0, 0);
        rst_n = 1'b0;
        tick();
        expect_outs("mid_rst", 16'h0001, 0, 6'h00, 4'h0, 4'h0, 4'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
